// File: rtl/three_phase_ref_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : three_phase_ref_gen_if
//  Description : U/f command inputs and three-phase reference outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface three_phase_ref_gen_if;
    logic               enable;
    logic        [15:0] amplitude;
    logic signed [15:0] phase;
    logic signed [15:0] ua;
    logic signed [15:0] ub;
    logic signed [15:0] uc;
    logic        [15:0] angle_out;
    logic               out_valid;

    modport master (
        output enable, amplitude, phase,
        input  ua, ub, uc, angle_out, out_valid
    );

    modport slave (
        input  enable, amplitude, phase,
        output ua, ub, uc, angle_out, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/three_phase_ref_gen.sv
`default_nettype none
// ============================================================================
//  Module      : three_phase_ref_gen
//  Description : Angle integrator plus sine-ROM / shared-multiplier sequencer
//                producing three 120-degree-spaced amplitude-scaled references.
//  Revision    : 1.0 - initial release
// ============================================================================
module three_phase_ref_gen #(
    parameter int SAMPLE_DIV = 4000,
    parameter int ANGLE_K    = 4295,
    parameter int AMP_MAX    = 30000
) (
    input  wire logic             clk_40_mhz,
    input  wire logic             reset,
    three_phase_ref_gen_if.slave  bus
);

    localparam int          DIV_W = $clog2(SAMPLE_DIV);
    localparam logic [31:0] OFF_B = 32'h5555_5555;
    localparam logic [31:0] OFF_C = 32'hAAAA_AAAB;

    typedef enum logic [3:0] {
        S_IDLE, S_LATCH, S_LUT_A, S_MUL_A, S_LUT_B,
        S_MUL_B, S_LUT_C, S_MUL_C, S_OUT
    } state_t;

    // Quarter-wave folded sine, evaluated at elaboration; k=0..256 covers 0..90 deg.
    function automatic logic signed [15:0] f_sin_entry(input int idx);
        int  k;
        bit  neg;
        real x;
        real term;
        real acc;
        k   = idx % 512;
        neg = (idx >= 512);
        if (k > 256) k = 512 - k;
        x    = 6.283185307179586 * real'(k) / 1024.0;
        term = x;
        acc  = x;
        for (int n = 1; n < 14; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            acc  = acc + term;
        end
        k = $rtoi(acc * 32767.0 + 0.5);
        return neg ? 16'(-k) : 16'(k);
    endfunction

    logic signed [15:0] w_sin_tab [1024];

    for (genvar gi = 0; gi < 1024; gi++) begin : g_sin_rom
        localparam logic signed [15:0] SIN_VAL = f_sin_entry(gi);
        assign w_sin_tab[gi] = SIN_VAL;
    end

    state_t             state_q;
    logic [DIV_W-1:0]   div_q;
    logic [DIV_W-1:0]   div_d;
    logic               tick_q;
    logic [31:0]        angle_q;
    logic [15:0]        amp_q;
    logic signed [15:0] rom_q;
    logic signed [15:0] shadow_a_q;
    logic signed [15:0] shadow_b_q;
    logic signed [15:0] ua_q;
    logic signed [15:0] ub_q;
    logic signed [15:0] uc_q;
    logic [15:0]        angle_out_q;
    logic               out_valid_q;

    logic               w_wrap;
    logic [31:0]        w_off;
    logic [9:0]         w_idx;
    logic [31:0]        w_inc;
    logic [15:0]        w_amp_clamped;
    logic signed [30:0] w_prod;
    logic signed [15:0] w_scaled;

    assign w_wrap = (div_q == DIV_W'(SAMPLE_DIV - 1));
    assign div_d  = w_wrap ? '0 : div_q + 1'b1;

    always_comb begin
        w_off = 32'd0;
        case (state_q)
            S_LUT_B: w_off = OFF_B;
            S_LUT_C: w_off = OFF_C;
            default: w_off = 32'd0;
        endcase
    end

    assign w_idx         = 10'((angle_q + w_off) >> 22);
    assign w_inc         = 32'(bus.phase) * 32'(ANGLE_K);
    assign w_amp_clamped = (bus.amplitude > 16'(AMP_MAX)) ? 16'(AMP_MAX) : bus.amplitude;
    // Amplitude <= 32767 and |sin| <= 32767, so the product fits 31 signed bits.
    assign w_prod        = 31'($signed({1'b0, amp_q})) * 31'(rom_q);
    assign w_scaled      = 16'(w_prod >>> 15);

    always_ff @(posedge clk_40_mhz) begin
        if (reset) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= w_wrap;
        end
    end

    // Outputs load on the MUL_C edge so that out_valid is visible during OUT,
    // eight cycles after the tick; the C product goes straight to uc.
    always_ff @(posedge clk_40_mhz) begin
        if (reset) begin
            state_q     <= S_IDLE;
            angle_q     <= '0;
            amp_q       <= '0;
            rom_q       <= '0;
            shadow_a_q  <= '0;
            shadow_b_q  <= '0;
            ua_q        <= '0;
            ub_q        <= '0;
            uc_q        <= '0;
            angle_out_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (tick_q) state_q <= S_LATCH;
                end
                S_LATCH: begin
                    amp_q <= bus.enable ? w_amp_clamped : 16'd0;
                    if (bus.enable) angle_q <= angle_q + w_inc;
                    state_q <= S_LUT_A;
                end
                S_LUT_A: begin
                    rom_q   <= w_sin_tab[w_idx];
                    state_q <= S_MUL_A;
                end
                S_MUL_A: begin
                    shadow_a_q <= w_scaled;
                    state_q    <= S_LUT_B;
                end
                S_LUT_B: begin
                    rom_q   <= w_sin_tab[w_idx];
                    state_q <= S_MUL_B;
                end
                S_MUL_B: begin
                    shadow_b_q <= w_scaled;
                    state_q    <= S_LUT_C;
                end
                S_LUT_C: begin
                    rom_q   <= w_sin_tab[w_idx];
                    state_q <= S_MUL_C;
                end
                S_MUL_C: begin
                    ua_q        <= shadow_a_q;
                    ub_q        <= shadow_b_q;
                    uc_q        <= w_scaled;
                    angle_out_q <= angle_q[31:16];
                    out_valid_q <= 1'b1;
                    state_q     <= S_OUT;
                end
                S_OUT: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ua        = ua_q;
    assign bus.ub        = ub_q;
    assign bus.uc        = uc_q;
    assign bus.angle_out = angle_out_q;
    assign bus.out_valid = out_valid_q;

endmodule
`default_nettype wire
